alu_result_stage: RTL

- Execute/writeback boundary register directly downstream of the 32-bit integer ALU.
- Captures Y_LO, Y_HI and the N/Z/V/C flags each cycle an operation is accepted.
- Owns the architectural HI and LO registers and resolves MFHI/MFLO selection.
- Presents one result per operation to writeback over a valid/ready handshake, with a 2-entry skid buffer so upstream may stall one cycle late.

---
 rtl/alu_result_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage
//   Execute/writeback boundary register that sits directly after the 32-bit
//   integer ALU. It owns the architectural HI/LO registers, resolves
//   MFHI/MFLO result selection, and hands one result per accepted operation
//   to writeback over a valid/ready handshake. A two-entry buffer (main
//   output register plus a skid register) lets upstream react to a stall
//   one cycle late.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous, active-low reset
//   in_valid   : ALU outputs and sideband are valid this cycle
//   in_ready   : stage can accept this cycle (registered)
//   FS         : function select of the op currently in the ALU
//   Y_LO/Y_HI  : ALU low/high result words
//   N,Z,V,C    : ALU flags
//   Y_Sel      : result source (00 Y_LO, 01 HI, 10 LO, 11 same as 00)
//   D_En       : destination write enable
//   D_Addr     : destination register number
//   out_valid  : result entry valid to writeback
//   out_ready  : writeback consumes the presented entry this cycle
//   ALU_OUT    : selected result of the presented entry
//   W_En       : captured D_En of the presented entry
//   W_Addr     : captured D_Addr of the presented entry
//   N_o..C_o   : captured flags of the presented entry
//   HI, LO     : architectural HI/LO registers
module alu_result_stage #(
  parameter logic [4:0] MUL_OP = 5'h1E,
  parameter logic [4:0] DIV_OP = 5'h1F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  FS,
  input  logic [31:0] Y_LO,
  input  logic [31:0] Y_HI,
  input  logic        N,
  input  logic        Z,
  input  logic        V,
  input  logic        C,
  input  logic [1:0]  Y_Sel,
  input  logic        D_En,
  input  logic [4:0]  D_Addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ALU_OUT,
  output logic        W_En,
  output logic [4:0]  W_Addr,
  output logic        N_o,
  output logic        Z_o,
  output logic        V_o,
  output logic        C_o,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef struct packed {
    logic [31:0] alu;
    logic        wEn;
    logic [4:0]  wAddr;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } entry_t;

  entry_t      main_q, main_d;
  entry_t      skid_q, skid_d;
  entry_t      newEntry;
  logic        mainValid_q, mainValid_d;
  logic        skidValid_q, skidValid_d;
  logic        inReady_q;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        acc;
  logic        mainFree;

  assign acc = in_valid & inReady_q;

  // Main register can take a new entry when it is empty or being consumed
  // this cycle; out_ready has no effect while main is empty.
  assign mainFree = ~mainValid_q | out_ready;

  // Build the entry for the op being offered. MFHI/MFLO read the HI/LO
  // registers as they stand before this edge, so an op accepted right after
  // a MUL/DIV already sees the committed values. Flags pass straight through.
  always_comb begin
    newEntry       = '0;
    newEntry.wEn   = D_En;
    newEntry.wAddr = D_Addr;
    newEntry.n     = N;
    newEntry.z     = Z;
    newEntry.v     = V;
    newEntry.c     = C;
    case (Y_Sel)
      2'b01:   newEntry.alu = hi_q;
      2'b10:   newEntry.alu = lo_q;
      default: newEntry.alu = Y_LO;
    endcase
  end

  // HI/LO commit at acceptance, independent of whether the entry later stalls.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (acc && (FS == MUL_OP || FS == DIV_OP)) begin
      hi_d = Y_HI;
      lo_d = Y_LO;
    end
  end

  // Entry movement, oldest first. When main frees up, a held skid entry
  // always moves into main before any newly accepted op, which then lands in
  // skid. When main is stalled, an accepted op parks in skid.
  always_comb begin
    main_d      = main_q;
    mainValid_d = mainValid_q;
    skid_d      = skid_q;
    skidValid_d = skidValid_q;
    if (mainFree) begin
      if (skidValid_q) begin
        main_d      = skid_q;
        mainValid_d = 1'b1;
        skidValid_d = acc;
        if (acc) begin
          skid_d = newEntry;
        end
      end else if (acc) begin
        main_d      = newEntry;
        mainValid_d = 1'b1;
      end else begin
        mainValid_d = 1'b0;
      end
    end else if (acc) begin
      skid_d      = newEntry;
      skidValid_d = 1'b1;
    end
  end

  // State registers. in_ready is registered from the next skid state so
  // there is no combinational path from out_ready; it resets low and rises
  // on the first edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q      <= '0;
      mainValid_q <= 1'b0;
      skid_q      <= '0;
      skidValid_q <= 1'b0;
      inReady_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      main_q      <= main_d;
      mainValid_q <= mainValid_d;
      skid_q      <= skid_d;
      skidValid_q <= skidValid_d;
      inReady_q   <= ~skidValid_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = mainValid_q;
  assign ALU_OUT   = main_q.alu;
  assign W_En      = main_q.wEn;
  assign W_Addr    = main_q.wAddr;
  assign N_o       = main_q.n;
  assign Z_o       = main_q.z;
  assign V_o       = main_q.v;
  assign C_o       = main_q.c;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule
